// File: rtl/crc8_serial_gen.sv
// Serial CRC-8 generator: passes data bits through with one-cycle latency, then appends
// the 8-bit CRC MSB first.
module crc8_serial_gen #(
  parameter logic [7:0] POLY = 8'h07,
  parameter logic [7:0] INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       din_valid,
  input  logic       din_last,
  output logic       din_ready,
  output logic       dout,
  output logic       dout_valid,
  output logic [7:0] crc_out,
  output logic       done,
  output logic       busy
);

  typedef enum logic {StData, StAppend} state_e;

  state_e     state_q, state_d;
  logic [7:0] crc_q, crc_d;
  logic [2:0] cnt_q, cnt_d;
  logic       dout_q, dout_d;
  logic       dout_valid_q, dout_valid_d;
  logic [7:0] crc_out_q, crc_out_d;
  logic       done_q, done_d;

  logic       accept;
  logic       fb;
  logic [7:0] crc_upd;

  assign din_ready = (state_q == StData);
  assign busy      = (state_q == StAppend);
  assign accept    = din_valid & din_ready;

  // One LFSR step; bit 7 is shifted out and only feeds the XOR tap.
  assign fb      = crc_q[7] ^ din;
  assign crc_upd = {crc_q[6:0], 1'b0} ^ (fb ? POLY : 8'h00);

  always_comb begin
    state_d      = state_q;
    crc_d        = crc_q;
    cnt_d        = cnt_q;
    dout_d       = 1'b0;
    dout_valid_d = 1'b0;
    crc_out_d    = crc_out_q;
    done_d       = 1'b0;
    unique case (state_q)
      StData: begin
        if (accept) begin
          dout_d       = din;
          dout_valid_d = 1'b1;
          crc_d        = crc_upd;
          if (din_last) begin
            crc_out_d = crc_upd;
            cnt_d     = 3'd7;
            state_d   = StAppend;
          end
        end
      end
      StAppend: begin
        // The CRC register doubles as the output shift register.
        dout_d       = crc_q[7];
        dout_valid_d = 1'b1;
        crc_d        = {crc_q[6:0], 1'b0};
        cnt_d        = cnt_q - 3'd1;
        if (cnt_q == 3'd0) begin
          state_d = StData;
          crc_d   = INIT;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StData;
      crc_q        <= INIT;
      cnt_q        <= 3'd0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      crc_out_q    <= 8'h00;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      crc_q        <= crc_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      crc_out_q    <= crc_out_d;
      done_q       <= done_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign crc_out    = crc_out_q;
  assign done       = done_q;

endmodule

// File: tb/tb_crc8_serial_gen.sv
// Scoreboard bench for crc8_serial_gen: driver pushes expected output bits and CRCs,
// a negedge monitor pops and compares whenever dout_valid is high.
module tb_crc8_serial_gen;

  localparam logic [7:0] Poly = 8'h07;

  typedef bit bitq_t[$];

  logic       clk = 1'b0;
  logic       rst;
  logic       din, din_valid, din_last;
  logic       din_ready, dout, dout_valid, done, busy;
  logic [7:0] crc_out;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_acc = 0;
  int first_acc = 0;
  int done_cyc = -1;
  bit mon_en = 1'b0;

  bit         exp_bit_q[$];
  bit         exp_done_q[$];
  logic [7:0] exp_crc_q[$];

  crc8_serial_gen #(.POLY(Poly), .INIT(8'h00)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_last  (din_last),
    .din_ready (din_ready),
    .dout      (dout),
    .dout_valid(dout_valid),
    .crc_out   (crc_out),
    .done      (done),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference CRC by polynomial long division of msg * x^8 by the generator.
  function automatic logic [7:0] crc_ref(input bitq_t m);
    bitq_t      r;
    bit   [8:0] g;
    logic [7:0] c;
    g = {1'b1, Poly};
    r = m;
    for (int k = 0; k < 8; k++) r.push_back(1'b0);
    for (int i = 0; i < m.size(); i++)
      if (r[i]) for (int j = 0; j < 9; j++) r[i+j] ^= g[8-j];
    for (int k = 0; k < 8; k++) c[7-k] = r[m.size()+k];
    return c;
  endfunction

  function automatic bitq_t byte_bits(input logic [7:0] v);
    bitq_t q;
    for (int i = 7; i >= 0; i--) q.push_back(v[i]);
    return q;
  endfunction

  task automatic idle_cycle();
    din_valid = 1'b0;
    din_last  = 1'($urandom);
    din       = 1'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input bit b, input bit last, output int acc);
    bit rdy;
    din = b; din_valid = 1'b1; din_last = last;
    acc = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      rdy = din_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        acc = cyc - 1;
        break;
      end
    end
    if (acc < 0) check("accept_timeout", 0, 1);
    din_valid = 1'b0; din_last = 1'b0; din = 1'b0;
  endtask

  // n_crc < 8 models an append that will be cut short by reset.
  task automatic send_frame(input bitq_t bits, input logic [7:0] exp_crc, input int gap_pct,
                            input int n_crc);
    int acc;
    foreach (bits[i]) begin
      exp_bit_q.push_back(bits[i]);
      exp_done_q.push_back(1'b0);
    end
    for (int k = 0; k < n_crc; k++) begin
      exp_bit_q.push_back(exp_crc[7-k]);
      exp_done_q.push_back(k == 7);
    end
    if (n_crc == 8) exp_crc_q.push_back(exp_crc);
    foreach (bits[i]) begin
      while (int'($urandom_range(99)) < gap_pct) idle_cycle();
      send_bit(bits[i], i == bits.size() - 1, acc);
      if (i == 0) first_acc = acc;
    end
    last_acc = acc;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (dout_valid === 1'b1) begin
        if (exp_bit_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          bit b, d;
          b = exp_bit_q.pop_front();
          d = exp_done_q.pop_front();
          check("dout_bit", 32'(dout), 32'(b));
          check("done_align", 32'(done), 32'(d));
          if (d && done === 1'b1) done_cyc = cyc;
          if (d) begin
            if (exp_crc_q.size() == 0) check("crc_queue_empty", 1, 0);
            else check("crc_out", 32'(crc_out), 32'(exp_crc_q.pop_front()));
          end
        end
      end else begin
        check("done_without_valid", 32'(done), 0);
      end
    end
  end

  initial begin
    bitq_t      bits;
    bitq_t      one;
    string      s;
    int         prev_last;
    logic [7:0] c;

    rst = 1'b1; din_valid = 1'b1; din = 1'b1; din_last = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_dout", 32'(dout), 0);
    check("rst_dout_valid", 32'(dout_valid), 0);
    check("rst_crc_out", 32'(crc_out), 0);
    check("rst_done", 32'(done), 0);
    check("rst_busy", 32'(busy), 0);
    @(posedge clk); #1;
    rst = 1'b0; din_valid = 1'b0; din_last = 1'b0; din = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(din_ready), 1);
    @(posedge clk); #1;

    // 8'h01: done must land nine cycles after the last accepted bit.
    send_frame(byte_bits(8'h01), 8'h07, 0, 8);
    @(negedge clk);
    check("append_busy", 32'(busy), 1);
    check("append_not_ready", 32'(din_ready), 0);
    repeat (10) @(posedge clk);
    #1;
    check("done_at_t9", 32'(done_cyc - last_acc), 9);

    send_frame(byte_bits(8'hFF), 8'hF3, 0, 8);
    repeat (10) idle_cycle();

    s = "123456789";
    bits = {};
    for (int i = 0; i < s.len(); i++) bits = {bits, byte_bits(s[i])};
    send_frame(bits, 8'hF4, 0, 8);
    send_frame(bits, 8'hF4, 35, 8);

    // Back-to-back: second frame's first bit held valid through the append.
    send_frame(byte_bits(8'h01), 8'h07, 0, 8);
    prev_last = last_acc;
    send_frame(byte_bits(8'hFF), 8'hF3, 0, 8);
    check("b2b_first_accept", 32'(first_acc - prev_last), 9);

    one = {1'b1};
    send_frame(one, 8'h07, 0, 8);
    prev_last = last_acc;
    send_frame(one, 8'h07, 0, 8);
    check("single_bit_b2b", 32'(first_acc - prev_last), 9);

    for (int f = 0; f < 6; f++) begin
      int len;
      len = int'($urandom_range(24, 1));
      bits = {};
      for (int i = 0; i < len; i++) bits.push_back(1'($urandom));
      send_frame(bits, crc_ref(bits), 30, 8);
    end
    repeat (10) idle_cycle();

    // Reset during the 4th CRC bit aborts the append.
    bits = byte_bits(8'hA5);
    c = crc_ref(bits);
    send_frame(bits, c, 0, 4);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_dout_valid", 32'(dout_valid), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_crc_out", 32'(crc_out), 0);
    check("abort_ready", 32'(din_ready), 1);
    @(posedge clk); #1;
    send_frame(byte_bits(8'h01), 8'h07, 0, 8);

    for (int n = 0; n < 60 && exp_bit_q.size() != 0; n++) @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("drain_bits", 32'(exp_bit_q.size()), 0);
    check("drain_crc", 32'(exp_crc_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/crc8_serial_gen.md
Name: crc8_serial_gen

Overview:
Serial CRC-8 generator stage that consumes the bit stream produced by the XOR/parity datapath. It computes the CRC one bit per clock using the same XOR feedback primitive, then appends the 8 CRC bits to the outgoing stream. Sits between the bitwise XOR datapath and the serial transmit/check logic. It provides frame-level integrity on a one-bit-wide path.

Parameters:
POLY, 8'h07, CRC-8 generator polynomial with the implicit x^8 term omitted.
INIT, 8'h00, CRC register value at reset and at the start of every frame.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
din  input  1  serial data bit.
din_valid  input  1  din is valid this cycle.
din_last  input  1  qualifies din as the final data bit of the frame.
din_ready  output  1  the block accepts din this cycle.
dout  output  1  serial output stream: data bits, then CRC bits MSB first.
dout_valid  output  1  dout is valid this cycle.
crc_out  output  8  final CRC of the most recent frame; held until the next frame completes.
done  output  1  one-cycle pulse, aligned with the last CRC bit on dout.
busy  output  1  high while the CRC append is in progress.

Behaviour:
- Reset, sampled on the clk edge while rst=1, overrides all other inputs:
  - state=DATA, crc=INIT, cnt=0.
  - dout=0, dout_valid=0, crc_out=8'h00, done=0, busy=0.
  - din_ready=1 from the first cycle after reset.
- Accept condition: din_valid & din_ready. din_ready = (state==DATA), driven combinationally from state.
- CRC update on each accepted bit:
  - fb = crc[7] ^ din.
  - crc <= {crc[6:0],1'b0} ^ (fb ? POLY : 8'h00).
  - All arithmetic is 8-bit; bit 7 shifts out and is discarded.
- Data passthrough: dout and dout_valid are registered, one-cycle latency.
  - In DATA, dout_valid <= accept and dout <= din (dout <= 0 when not accepting).
  - Gaps with din_valid=0 produce dout_valid=0 and leave crc unchanged.
- State DATA -> APPEND when an accepted bit has din_last=1. On that edge:
  - crc_out <= the updated CRC.
  - crc <= the updated CRC, used as the shift register.
  - cnt <= 7.
- State APPEND (8 cycles): din_ready=0, busy=1. Each edge:
  - dout <= crc[7], dout_valid <= 1.
  - crc <= {crc[6:0],1'b0}.
  - cnt decrements.
  - When cnt==0: state <= DATA, crc <= INIT, done <= 1 for one cycle.
- Timing if the last bit is accepted in cycle T:
  - Last data bit appears on dout in T+1.
  - CRC bits 7..0 appear in T+2..T+9; done=1 in T+9.
  - din_ready is low in T+1..T+8 and high again in T+9.
  - A new frame's first bit may be accepted in T+9; its passthrough appears in T+10 with no bubble.
- din_valid while din_ready=0 is ignored: no CRC update, no output.
- A single-bit frame (first bit has din_last=1) is legal and yields 9 output bits.
- din_last with din_valid=0 is ignored.
- Reset mid-APPEND aborts the append. No done pulse; crc_out is cleared to 8'h00.
- crc_out changes only on last-bit acceptance or reset.

Test Plan:
- Reset: hold rst for 2 cycles with din_valid=1 -> all outputs 0; din_ready=1 on the first post-reset cycle.
- Byte 8'h01 sent MSB first, last on bit 0 -> crc_out=8'h07; dout sequence 00000001 then 00000111; done pulse at T+9.
- Byte 8'hFF -> crc_out=8'hF3. ASCII "123456789" as 72 bits -> crc_out=8'hF4, with din_valid gaps randomly inserted and the same result.
- Back-to-back frames 8'h01 then 8'hFF, second frame's first bit held valid from T+1 -> not accepted before T+9; second crc_out=8'hF3, proving CRC re-initialised to INIT.
- Assert din_valid during APPEND -> no effect on dout or CRC. Single-bit frame din=1 -> crc_out=8'h07 and 9 output bits.
- Assert rst at the 4th CRC bit -> next cycle dout_valid=0, busy=0, done never pulses, crc_out=0; a following frame 8'h01 gives 8'h07.
